aes_stream_ctrl: RTL and testbench

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

---
 rtl/aes_stream_pkg.sv | 9 +
 rtl/aes_stream_fifo.sv | 75 +++++++
 rtl/aes_stream_ctrl.sv | 104 ++++++++++
 tb/tb_aes_stream_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared constants for the AES streaming wrapper: block width and the default
// core latency / result buffer depth.
package aes_stream_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int AES_LATENCY    = 21;
  localparam int AES_FIFO_DEPTH = 32;

endpackage

// File: rtl/aes_stream_fifo.sv
// Synchronous show-ahead FIFO with an occupancy count; the head entry is
// presented on rd_data while non-empty and zero otherwise.
module aes_stream_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = AES_FIFO_DEPTH,
  parameter int WIDTH = AES_BLOCK_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             wr_s;
  logic             rd_s;

  // Writes into a full FIFO are dropped; the credit scheme upstream never issues them.
  assign wr_s  = wr_en & (count_r != CNT_FULL);
  assign rd_s  = rd_en & (count_r != CNT_ZERO);
  assign count = count_r;

  // Show-ahead head, forced to zero when empty
  always_comb begin
    rd_data = {WIDTH{1'b0}};
    if (count_r != CNT_ZERO) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  // Storage array, data only, no reset needed
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streaming wrapper around an external fixed-latency aes_128 core: credit-based
// admission, a valid shift register tracking the core pipeline, and an ordered result FIFO.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int LATENCY    = AES_LATENCY,
  parameter int FIFO_DEPTH = AES_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_pt,
  input  logic [AES_BLOCK_W-1:0] in_key,
  output logic [AES_BLOCK_W-1:0] core_state,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic [AES_BLOCK_W-1:0] core_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_ct,
  output logic                   busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  logic [LATENCY-1:0]     valid_sr_r;
  logic [LATENCY-1:0]     valid_nxt_s;
  logic [CW-1:0]          inflight_r;
  logic [CW-1:0]          inflight_nxt_s;
  logic [CW-1:0]          fifo_count_s;
  logic [CW:0]            credit_used_s;
  logic                   accept_s;
  logic                   capture_s;
  logic                   pop_s;
  logic                   out_valid_s;
  logic [AES_BLOCK_W-1:0] fifo_head_s;

  // Every slot in the core pipeline or the FIFO holds one credit, so a capture
  // always finds room; in_ready depends on registered counters only.
  assign credit_used_s = {1'b0, inflight_r} + {1'b0, fifo_count_s};
  assign in_ready      = (credit_used_s < CREDIT_MAX);
  assign accept_s      = in_valid & in_ready & rst_n;
  assign capture_s     = valid_sr_r[LATENCY-1];
  assign out_valid_s   = (fifo_count_s != CNT_ZERO);
  assign pop_s         = out_valid_s & out_ready;
  assign out_valid     = out_valid_s;
  assign out_ct        = fifo_head_s;
  assign busy          = (inflight_r != CNT_ZERO) | out_valid_s;

  // Core data inputs carry the pair only in the accept cycle
  always_comb begin
    core_state = {AES_BLOCK_W{1'b0}};
    core_key   = {AES_BLOCK_W{1'b0}};
    if (accept_s) begin
      core_state = in_pt;
      core_key   = in_key;
    end else begin
      core_state = {AES_BLOCK_W{1'b0}};
      core_key   = {AES_BLOCK_W{1'b0}};
    end
  end

  // Next valid stages and in-flight count
  always_comb begin
    valid_nxt_s    = {LATENCY{1'b0}};
    valid_nxt_s[0] = accept_s;
    for (int i = 1; i < LATENCY; i++) begin
      valid_nxt_s[i] = valid_sr_r[i-1];
    end
    case ({accept_s, capture_s})
      2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
      2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Clearing the valid stages on reset keeps stale core results from ever being captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr_r <= {LATENCY{1'b0}};
      inflight_r <= CNT_ZERO;
    end else begin
      valid_sr_r <= valid_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  aes_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AES_BLOCK_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture_s),
    .wr_data (core_out),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .count   (fifo_count_s)
  );

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural AES-128 core with matching latency,
// scoreboard of expected ciphertexts, and a per-cycle occupancy/credit model.
module tb_aes_stream_ctrl;

  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic         busy;

  int n_tests;
  int n_fail;
  int acc_total;
  int pop_total;

  logic [127:0] sb_q[$];
  logic [7:0]   sbox_tab [256];
  logic [127:0] core_pipe [LATENCY];

  logic [LATENCY-1:0] m_vs;
  int                 m_infl;
  int                 m_fifo;

  aes_stream_ctrl #(
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pt      (in_pt),
    .in_key     (in_key),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ct     (out_ct),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box built from the GF(2^8) inverse followed by the affine transform
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] xb;
    logic [7:0] yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (x != 0 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[q+4*c] = t[q+4*((c+q)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // External aes_128 stand-in: samples on an edge, result visible LATENCY edges later
  // counting the sampling edge; not reset, so stale data stays in the pipe.
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  // Monitor: sample mid-cycle, check outputs against the model, then advance it for the next edge
  always @(negedge clk) begin
    bit acc;
    bit pop;
    bit cap;
    if (!rst_n) begin
      sb_q.delete();
      m_vs   = '0;
      m_infl = 0;
      m_fifo = 0;
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_ct", out_ct, 128'h0);
      check_eq("rst_busy", busy, 1'b0);
    end else begin
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      cap = m_vs[LATENCY-1];
      check_eq("in_ready", in_ready, (m_infl + m_fifo) < FIFO_DEPTH);
      check_eq("out_valid", out_valid, m_fifo != 0);
      check_eq("busy", busy, (m_infl != 0) || (m_fifo != 0));
      check_eq("core_state", core_state, acc ? in_pt : 128'h0);
      check_eq("core_key", core_key, acc ? in_key : 128'h0);
      check_eq("no_overflow", cap && (m_fifo == FIFO_DEPTH) && !pop, 1'b0);
      if (acc) begin
        sb_q.push_back(aes_enc(in_pt, in_key));
        acc_total++;
      end
      if (pop) begin
        check_eq("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) check_eq("out_ct", out_ct, sb_q.pop_front());
        pop_total++;
      end else if (!out_valid) begin
        check_eq("out_ct_idle", out_ct, 128'h0);
      end
      m_infl = m_infl + int'(acc) - int'(cap);
      m_fifo = m_fifo + int'(cap) - int'(pop);
      m_vs   = {m_vs[LATENCY-2:0], acc};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check_eq("drain_done", busy, 1'b0);
  endtask

  task automatic rand_pair();
    in_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_key = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int acc0;
    int pop0;
    int acc3;
    int pop3;
    int quiet_bad;
    n_tests   = 0;
    n_fail    = 0;
    acc_total = 0;
    pop_total = 0;
    build_sbox();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pt     = 128'h0;
    in_key    = 128'h0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("reset_core_state", core_state, 128'h0);
    check_eq("reset_core_key", core_key, 128'h0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 vector and first-result latency
    in_pt    = 128'h00112233445566778899aabbccddeeff;
    in_key   = 128'h000102030405060708090a0b0c0d0e0f;
    in_valid = 1'b1;
    #1;
    check_eq("fips_core_state", core_state, 128'h00112233445566778899aabbccddeeff);
    check_eq("fips_core_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);
    tick();
    in_valid = 1'b0;
    edges = 1;  // the accept edge itself
    while (!out_valid && edges < LATENCY + 10) begin
      tick();
      edges++;
    end
    check_eq("fips_latency", edges, LATENCY + 1);
    check_eq("fips_ct", out_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain(100);

    // 40 back-to-back blocks with a ready consumer
    pop0 = pop_total;
    for (int i = 0; i < 40; i++) begin
      rand_pair();
      in_valid = 1'b1;
      #1;
      check_eq("b2b_in_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    drain(200);
    check_eq("b2b_count", pop_total - pop0, 40);

    // Stalled consumer: exactly FIFO_DEPTH accepts
    out_ready = 1'b0;
    acc3 = acc_total;
    pop3 = pop_total;
    in_valid = 1'b1;
    repeat (FIFO_DEPTH + LATENCY + 5) begin
      rand_pair();
      tick();
    end
    check_eq("fill_accepts", acc_total - acc3, FIFO_DEPTH);
    check_eq("fill_in_ready", in_ready, 1'b0);

    // Full FIFO with toggling consumer: each pop frees exactly one accept
    acc0 = acc_total;
    pop0 = pop_total;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2 == 0);
      rand_pair();
      tick();
    end
    check_eq("toggle_pops", pop_total - pop0, 20);
    check_eq("toggle_accepts", acc_total - acc0, pop_total - pop0);
    check_eq("toggle_full", in_ready, 1'b0);

    // Offer while not ready: nothing reaches the core, nothing is accepted
    acc0 = acc_total;
    check_eq("blocked_core_state", core_state, 128'h0);
    check_eq("blocked_core_key", core_key, 128'h0);
    tick();
    check_eq("blocked_no_accept", acc_total - acc0, 0);
    check_eq("blocked_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(300);
    check_eq("fill_none_lost", pop_total - pop3, acc_total - acc3);

    // Reset with blocks in flight
    for (int i = 0; i < 5; i++) begin
      rand_pair();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check_eq("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_out_ct", out_ct, 128'h0);
    check_eq("mid_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    quiet_bad = 0;
    repeat (LATENCY + 2) begin
      tick();
      if (out_valid) quiet_bad++;
    end
    check_eq("post_rst_quiet", quiet_bad, 0);
    check_eq("sb_empty_end", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
